instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Program loader for the single-cycle MIPS. It is the encoding counterpart of the main control decoder: it accepts instruction descriptions (kind plus fields) over a valid/ready handshake and assembles 32-bit MIPS words. It writes the words sequentially into instruction memory starting at BASE_ADDR. It sits between the testbench/host loader and the instruction-memory write port, and is used before the core is released from reset.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
BASE_ADDR, 0, first word address written after start

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  pulse: clear counters/error, enter LOAD
finish  in  1  pulse: end of program, enter DONE
in_valid  in  1  instruction description valid
in_ready  out  1  block can accept this cycle
kind  in  3  0=R-type, 1=lw, 2=sw, 3=beq, 4=addi, 5=j, 6/7 illegal
rs, rt, rd, shamt  in  5 each  register/shift fields
funct  in  6  R-type function code
imm  in  16  immediate/offset for lw/sw/beq/addi
target  in  26  jump target field
mem_we  out  1  instruction-memory write strobe
mem_addr  out  ADDR_W  write word address
mem_wdata  out  32  encoded instruction
count  out  ADDR_W+1  words written since start
busy  out  1  state is LOAD or FULL
done  out  1  state is DONE
error  out  1  sticky: illegal kind received

Behaviour:
- States: IDLE, LOAD, FULL, DONE. Reset -> IDLE. Reset values: all outputs 0; internal write pointer = BASE_ADDR.
- Reset mid-load: mem_we is 0 from the cycle after reset is sampled. Memory contents are untouched.
- start (any state, takes priority over finish and in_valid) -> LOAD. count=0, pointer=BASE_ADDR, error=0. Any write already registered still completes the following cycle.
- in_ready = (state==LOAD) && !reset.
- Transfer = in_valid && in_ready at a rising edge.
- Latency 1: a transfer at edge N drives mem_we=1, mem_addr=pointer, mem_wdata=encoding for exactly the cycle after edge N. The pointer and count increment at the same edge N.
- Back-to-back transfers give a write every cycle.
- Encoding:
  - R: {000000, rs, rt, rd, shamt, funct}
  - lw: {100011, rs, rt, imm}
  - sw: {101011, rs, rt, imm}
  - beq: {000100, rs, rt, imm}
  - addi: {001000, rs, rt, imm}
  - j: {000010, target}
  - Fields unused by a kind are ignored.
- Illegal kind (6/7) on a transfer: no write, count unchanged, error set (sticky until start or reset).
- Pointer wraps modulo 2^ADDR_W.
- When count reaches 2^ADDR_W: LOAD -> FULL at that edge, in_ready=0. FULL leaves only via start, finish or reset.
- finish in LOAD or FULL -> DONE.
  - If finish coincides with a transfer, the instruction is accepted and written, then DONE.
  - finish in IDLE or DONE is ignored.
- DONE holds count and error until start or reset.
- mem_we is never asserted in IDLE except for the trailing write after a start/finish edge.

Test Plan:
- Reset, start, kind=0 rs=1 rt=2 rd=3 shamt=0 funct=100000 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00221820; count=1.
- Back-to-back lw (rs=16 rt=8 imm=4), sw (rs=0 rt=2 imm=8), beq (rs=1 rt=2 imm=0xFFFF), addi (rs=0 rt=2 imm=5), j (target=0x100000) -> writes on consecutive cycles at addr 0..4 of 0x8E080004, 0xAC020008, 0x1022FFFF, 0x20020005, 0x08100000; count=5.
- kind=6 mid-stream -> no mem_we that cycle, error=1, count unchanged, next legal instruction written at the next address.
- ADDR_W=2: five valid instructions -> four writes at addr 0..3, state FULL, in_ready=0 after the 4th, 5th held off; finish -> done=1, count=4.
- finish coinciding with a transfer -> that word written, done=1, in_ready=0. Then start -> count=0, error=0, next write at BASE_ADDR.
- Reset asserted during a stream -> mem_we=0 next cycle, count=0, busy=0, done=0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: assembles MIPS instruction words and streams them into instruction memory.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, FULL = 2'd2, DONE = 2'd3;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d, we_q;
  logic [31:0]       wdata_q, enc;
  logic [5:0]        op;
  logic              xfer, legal, wr;
  always_comb begin
    op  = kind == 3'd0 ? 6'h00 : kind == 3'd1 ? 6'h23 : kind == 3'd2 ? 6'h2b :
          kind == 3'd3 ? 6'h04 : kind == 3'd4 ? 6'h08 : 6'h02;
    enc = kind == 3'd0 ? {op, rs, rt, rd, shamt, funct} :
          kind == 3'd5 ? {op, target} : {op, rs, rt, imm};
  end
  // start outranks any handshake on the same edge
  always_comb begin
    xfer    = in_valid && in_ready;
    legal   = kind < 3'd6;
    wr      = xfer && legal && !start;
    count_d = start ? '0 : wr ? count_q + 1'b1 : count_q;
    ptr_d   = start ? BASE : wr ? ptr_q + 1'b1 : ptr_q;
    err_d   = start ? 1'b0 : (xfer && !legal) ? 1'b1 : err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = start ? LOAD :
              (finish && (state_q == LOAD || state_q == FULL)) ? DONE :
              (wr && count_d[ADDR_W]) ? FULL : state_q;
  end
  always_comb begin
    in_ready = state_q == LOAD && !reset;
    busy     = state_q == LOAD || state_q == FULL;
    done     = state_q == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= BASE;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= wr;
      if (wr) begin
        addr_q  <= ptr_q;
        wdata_q <= enc;
      end
    end
  end
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign error     = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with a write scoreboard over an 8-bit and a 2-bit address instance.
module tb_instr_encoder;
  logic clk = 0, reset = 1, start = 0, finish = 0, in_valid = 0, sel = 0;
  logic [2:0] kind = 0;
  logic [4:0] rs = 0, rt = 0, rd = 0, shamt = 0;
  logic [5:0] funct = 0;
  logic [15:0] imm = 0;
  logic [25:0] target = 0;
  logic r1, we1, b1, d1, e1, r2, we2, b2, d2, e2;
  logic [7:0] a1;
  logic [1:0] a2;
  logic [31:0] w1, w2;
  logic [8:0] c1;
  logic [2:0] c2;
  logic m_ready, m_busy, m_done, m_err;
  logic [8:0] m_count;
  int tests = 0, fails = 0;
  typedef struct packed {logic [7:0] a; logic [31:0] d;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start && !sel), .finish(finish && !sel),
    .in_valid(in_valid && !sel), .in_ready(r1), .kind(kind), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm), .target(target), .mem_we(we1),
    .mem_addr(a1), .mem_wdata(w1), .count(c1), .busy(b1), .done(d1), .error(e1));
  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start && sel), .finish(finish && sel),
    .in_valid(in_valid && sel), .in_ready(r2), .kind(kind), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm), .target(target), .mem_we(we2),
    .mem_addr(a2), .mem_wdata(w2), .count(c2), .busy(b2), .done(d2), .error(e2));
  assign m_ready = sel ? r2 : r1;
  assign m_busy  = sel ? b2 : b1;
  assign m_done  = sel ? d2 : d1;
  assign m_err   = sel ? e2 : e1;
  assign m_count = sel ? {6'd0, c2} : c1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", n, act, exp);
    end
  endtask
  task automatic mon(input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_write: got addr %h data %h required no write", a, d);
    end else begin
      e = q.pop_front();
      chk("wr_addr", 32'(a), 32'(e.a));
      chk("wr_data", d, e.d);
    end
  endtask
  always @(negedge clk) begin
    if (we1) mon(a1, w1);
    if (we2) mon({6'd0, a2}, w2);
  end
  task automatic send(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [5:0] f, input logic [15:0] i,
                      input logic [25:0] tg, input bit push, input logic [7:0] ea,
                      input logic [31:0] ew);
    int n = 0;
    kind = k; rs = s; rt = t; rd = d; shamt = 0; funct = f; imm = i; target = tg;
    in_valid = 1;
    if (push) q.push_back(exp_t'({ea, ew}));
    while (!m_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0 required 1");
    end else begin
      @(posedge clk); #1;
    end
  endtask
  task automatic do_start();
    in_valid = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(we1), 0);
    chk("rst_count", 32'(c1), 0);
    chk("rst_busy", 32'(b1), 0);
    chk("rst_done", 32'(d1), 0);
    chk("rst_err", 32'(e1), 0);
    chk("rst_ready", 32'(r1), 0);
    reset = 0;
    do_start();
    chk("start_busy", 32'(m_busy), 1);
    chk("start_ready", 32'(m_ready), 1);
    send(0, 1, 2, 3, 6'b100000, 0, 0, 1, 0, 32'h00221820);
    in_valid = 0;
    chk("r_count", 32'(m_count), 1);
    @(posedge clk); #1;
    do_start();
    send(1, 16, 8, 0, 0, 16'h0004, 0, 1, 0, 32'h8E080004);
    send(2, 0, 2, 0, 0, 16'h0008, 0, 1, 1, 32'hAC020008);
    send(3, 1, 2, 0, 0, 16'hFFFF, 0, 1, 2, 32'h1022FFFF);
    send(4, 0, 2, 0, 0, 16'h0005, 0, 1, 3, 32'h20020005);
    send(5, 0, 0, 0, 0, 0, 26'h0100000, 1, 4, 32'h08100000);
    in_valid = 0;
    chk("b2b_count", 32'(m_count), 5);
    chk("b2b_err", 32'(m_err), 0);
    send(6, 1, 1, 1, 0, 16'h1234, 0, 0, 0, 0);
    chk("ill_err", 32'(m_err), 1);
    chk("ill_count", 32'(m_count), 5);
    send(4, 1, 3, 0, 0, 16'h0007, 0, 1, 5, 32'h20230007);
    in_valid = 0;
    chk("post_ill_count", 32'(m_count), 6);
    finish = 1;
    send(5, 0, 0, 0, 0, 0, 26'h3FFFFFF, 1, 6, 32'h0BFFFFFF);
    finish = 0; in_valid = 0;
    chk("fin_done", 32'(m_done), 1);
    chk("fin_ready", 32'(m_ready), 0);
    chk("fin_busy", 32'(m_busy), 0);
    chk("fin_count", 32'(m_count), 7);
    chk("fin_err_held", 32'(m_err), 1);
    @(posedge clk); #1;
    do_start();
    chk("restart_count", 32'(m_count), 0);
    chk("restart_err", 32'(m_err), 0);
    chk("restart_done", 32'(m_done), 0);
    send(2, 5, 6, 0, 0, 16'h0010, 0, 1, 0, 32'hACA60010);
    send(1, 1, 2, 0, 0, 16'h0001, 0, 1, 1, 32'h8C220001);
    reset = 1;
    kind = 0;
    @(posedge clk); #1;
    chk("mid_rst_we", 32'(we1), 0);
    chk("mid_rst_count", 32'(m_count), 0);
    chk("mid_rst_busy", 32'(m_busy), 0);
    chk("mid_rst_done", 32'(m_done), 0);
    reset = 0; in_valid = 0;
    @(posedge clk); #1;
    sel = 1;
    do_start();
    send(0, 1, 2, 3, 6'b100000, 0, 0, 1, 0, 32'h00221820);
    send(4, 0, 2, 0, 0, 16'h0005, 0, 1, 1, 32'h20020005);
    send(3, 1, 2, 0, 0, 16'hFFFF, 0, 1, 2, 32'h1022FFFF);
    send(5, 0, 0, 0, 0, 0, 26'h0100000, 1, 3, 32'h08100000);
    chk("full_ready", 32'(m_ready), 0);
    chk("full_busy", 32'(m_busy), 1);
    chk("full_count", 32'(m_count), 4);
    kind = 1; rs = 3; rt = 4; imm = 16'h0009;
    repeat (3) @(posedge clk);
    #1;
    chk("held_ready", 32'(m_ready), 0);
    chk("held_count", 32'(m_count), 4);
    finish = 1;
    @(posedge clk); #1;
    finish = 0; in_valid = 0;
    chk("full_fin_done", 32'(m_done), 1);
    chk("full_fin_count", 32'(m_count), 4);
    chk("full_fin_busy", 32'(m_busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
